// File: rtl/ram_dma_pkg.sv
// Shared types and defaults for the SSRAM port-B DMA engine.
// FSM state encoding, default widths and the bus byte stride.
package ram_dma_pkg;

  localparam int defaultRamAddrWidth   = 9;
  localparam int defaultBlockSizeWidth = 10;
  localparam int defaultBurstSizeWidth = 8;

  localparam logic [31:0] byteIncrement = 32'd4;

  typedef enum logic [3:0] {
    IDLE,
    REQUEST,
    BEGIN,
    READ_BEATS,
    PREFETCH,
    WRITE_BEATS,
    END_WRITE,
    NEXT,
    ERROR_FLUSH
  } dmaStateT;

endpackage

// File: rtl/ram_dma_burst_counter.sv
// Beat counter for one bus burst, shared by both transfer directions.
// Ports: clock/reset, load+loadValue (beats-1), advance; lastBeat, exhausted.
module ram_dma_burst_counter
  import ram_dma_pkg::*;
#(
  parameter int burstSizeWidth = defaultBurstSizeWidth
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [burstSizeWidth-1:0] loadValue,
  input  logic                      advance,
  output logic                      lastBeat,
  output logic                      exhausted
);

  logic [burstSizeWidth-1:0] count;
  logic                      spent;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      spent <= 1'b0;
    end else if (load) begin
      count <= loadValue;
      spent <= 1'b0;
    end else if (advance && !spent) begin
      if (count == '0) spent <= 1'b1;
      else             count <= count - 1'b1;
    end
  end

  // Once the programmed beats are consumed, later beats are ignored.
  assign lastBeat  = !spent && (count == '0);
  assign exhausted = spent;

endmodule

// File: rtl/ram_dma_port_b_engine.sv
// DMA master on SSRAM port B: moves blocks bus<->SSRAM in bursts.
// Ports: config+start from CI decoder, SSRAM port B, bus-master handshake;
// optional doneIrq output when RAM_DMA_DONE_IRQ_EN is defined.
module ram_dma_port_b_engine
  import ram_dma_pkg::*;
#(
  parameter int ramAddrWidth   = defaultRamAddrWidth,
  parameter int blockSizeWidth = defaultBlockSizeWidth,
  parameter int burstSizeWidth = defaultBurstSizeWidth
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      toRam,
  input  logic [31:0]               busStartAddr,
  input  logic [ramAddrWidth-1:0]   ramStartAddr,
  input  logic [blockSizeWidth-1:0] blockSize,
  input  logic [burstSizeWidth-1:0] burstSize,
  output logic                      busy,
  output logic                      errorFlag,
  output logic [ramAddrWidth-1:0]   ramAddressB,
  output logic                      ramWriteEnableB,
  output logic [31:0]               ramDataInB,
  input  logic [31:0]               ramDataOutB,
  output logic                      requestBus,
  input  logic                      busGrant,
  output logic                      beginTransaction,
  output logic [31:0]               addressData,
  output logic                      readNotWrite,
  output logic [burstSizeWidth-1:0] burstLength,
  output logic                      dataValidOut,
  input  logic                      busBusy,
  input  logic                      dataValidIn,
  input  logic [31:0]               dataIn,
  input  logic                      endTransactionIn,
  output logic                      endTransactionOut,
`ifdef RAM_DMA_DONE_IRQ_EN
  output logic                      doneIrq,
`endif
  input  logic                      busErrorIn
);

  dmaStateT                  state;
  logic                      toRamQ;
  logic [burstSizeWidth-1:0] burstSizeQ;
  logic [31:0]               busAddr;
  logic [ramAddrWidth-1:0]   ramAddr;
  logic [blockSizeWidth-1:0] remaining;

  logic [blockSizeWidth-1:0] remMinus1;
  logic [burstSizeWidth-1:0] burstBeats;
  logic                      readBeat;
  logic                      writeAdvance;
  logic                      lastBeat;
  logic                      exhausted;

  // Burst is clipped to what is left of the block.
  assign remMinus1  = remaining - blockSizeWidth'(1);
  assign burstBeats = (32'(remMinus1) < 32'(burstSizeQ))
                    ? burstSizeWidth'(remMinus1) : burstSizeQ;

  assign readBeat = (state == READ_BEATS) && dataValidIn
                 && !busErrorIn && !exhausted;
  assign writeAdvance = (state == WRITE_BEATS) && !busBusy
                     && !busErrorIn;

  ram_dma_burst_counter #(
    .burstSizeWidth(burstSizeWidth)
  ) beatCounter (
    .clock    (clock),
    .reset    (reset),
    .load     (state == BEGIN),
    .loadValue(burstBeats),
    .advance  (readBeat || writeAdvance),
    .lastBeat (lastBeat),
    .exhausted(exhausted)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      toRamQ     <= 1'b0;
      burstSizeQ <= '0;
      busAddr    <= '0;
      ramAddr    <= '0;
      remaining  <= '0;
      errorFlag  <= 1'b0;
    end else if (busErrorIn && state != IDLE
                 && state != ERROR_FLUSH) begin
      state     <= ERROR_FLUSH;
      errorFlag <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          toRamQ     <= toRam;
          burstSizeQ <= burstSize;
          busAddr    <= busStartAddr;
          ramAddr    <= ramStartAddr;
          remaining  <= blockSize;
          errorFlag  <= 1'b0;
          // Zero length passes through NEXT: one busy cycle.
          state <= (blockSize == '0) ? NEXT : REQUEST;
        end
        REQUEST: if (busGrant) state <= BEGIN;
        BEGIN: state <= toRamQ ? READ_BEATS : PREFETCH;
        READ_BEATS: begin
          if (readBeat) begin
            ramAddr   <= ramAddr + ramAddrWidth'(1);
            busAddr   <= busAddr + byteIncrement;
            remaining <= remMinus1;
          end
          if (endTransactionIn) state <= NEXT;
        end
        PREFETCH: state <= WRITE_BEATS;
        WRITE_BEATS: if (writeAdvance) begin
          ramAddr   <= ramAddr + ramAddrWidth'(1);
          busAddr   <= busAddr + byteIncrement;
          remaining <= remMinus1;
          if (lastBeat) state <= END_WRITE;
        end
        END_WRITE: state <= NEXT;
        NEXT: state <= (remaining == '0) ? IDLE : REQUEST;
        ERROR_FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_DMA_DONE_IRQ_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      doneIrq <= 1'b0;
    end else if (state == IDLE && start) begin
      doneIrq <= 1'b0;
    end else if (state == ERROR_FLUSH
                 || (state == NEXT && remaining == '0
                     && !busErrorIn)) begin
      doneIrq <= 1'b1;
    end
  end
`endif

  always_comb begin
    busy             = (state != IDLE);
    requestBus       = state inside {REQUEST, BEGIN,
                         READ_BEATS, PREFETCH,
                         WRITE_BEATS, END_WRITE};
    beginTransaction = (state == BEGIN);
    readNotWrite     = (state == BEGIN) && toRamQ;
    burstLength      = (state == BEGIN) ? burstBeats : '0;
    dataValidOut     = (state == WRITE_BEATS);
    endTransactionOut = (state == END_WRITE);
    ramWriteEnableB  = readBeat;
    ramDataInB       = readBeat ? dataIn : '0;
    addressData      = '0;
    ramAddressB      = '0;
    unique case (1'b1)
      (state == BEGIN):
        addressData = busAddr & 32'hFFFF_FFFC;
      (state == WRITE_BEATS): begin
        addressData = ramDataOutB;
        // Read one ahead so beats stream; hold on stall.
        ramAddressB = busBusy ? ramAddr
                    : ramAddr + ramAddrWidth'(1);
      end
      (state == READ_BEATS || state == PREFETCH):
        ramAddressB = ramAddr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_dma_port_b_engine.sv
// Self-checking bench for ram_dma_port_b_engine with SSRAM and bus slave model.
// Optional doneIrq checks when RAM_DMA_DONE_IRQ_EN is defined.
module tb_ram_dma_port_b_engine;

  logic        clock = 0;
  logic        reset = 0;
  logic        start = 0;
  logic        toRam = 0;
  logic [31:0] busStartAddr = 0;
  logic [8:0]  ramStartAddr = 0;
  logic [9:0]  blockSize = 0;
  logic [7:0]  burstSize = 0;
  logic        busy, errorFlag;
  logic [8:0]  ramAddressB;
  logic        ramWriteEnableB;
  logic [31:0] ramDataInB;
  logic [31:0] ramDataOutB = 0;
  logic        requestBus;
  logic        busGrant = 0;
  logic        beginTransaction;
  logic [31:0] addressData;
  logic        readNotWrite;
  logic [7:0]  burstLength;
  logic        dataValidOut;
  logic        busBusy = 0;
  logic        dataValidIn = 0;
  logic [31:0] dataIn = 0;
  logic        endTransactionIn = 0;
  logic        endTransactionOut;
  logic        busErrorIn = 0;
`ifdef RAM_DMA_DONE_IRQ_EN
  logic        doneIrq;
`endif

  logic [31:0] ram [512];
  logic [31:0] expMem [512];
  logic        tbWe = 0;
  logic [8:0]  tbAddr = 0;
  logic [31:0] tbData = 0;

  int testsRun = 0;
  int testsFailed = 0;

  ram_dma_port_b_engine dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .toRam            (toRam),
    .busStartAddr     (busStartAddr),
    .ramStartAddr     (ramStartAddr),
    .blockSize        (blockSize),
    .burstSize        (burstSize),
    .busy             (busy),
    .errorFlag        (errorFlag),
    .ramAddressB      (ramAddressB),
    .ramWriteEnableB  (ramWriteEnableB),
    .ramDataInB       (ramDataInB),
    .ramDataOutB      (ramDataOutB),
    .requestBus       (requestBus),
    .busGrant         (busGrant),
    .beginTransaction (beginTransaction),
    .addressData      (addressData),
    .readNotWrite     (readNotWrite),
    .burstLength      (burstLength),
    .dataValidOut     (dataValidOut),
    .busBusy          (busBusy),
    .dataValidIn      (dataValidIn),
    .dataIn           (dataIn),
    .endTransactionIn (endTransactionIn),
    .endTransactionOut(endTransactionOut),
`ifdef RAM_DMA_DONE_IRQ_EN
    .doneIrq          (doneIrq),
`endif
    .busErrorIn       (busErrorIn)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tbWe) ram[tbAddr] <= tbData;
    else if (ramWriteEnableB) ram[ramAddressB] <= ramDataInB;
    ramDataOutB <= ram[ramAddressB];
  end

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseStart(input logic dir, input logic [31:0] bStart,
                            input logic [8:0] rStart, input logic [9:0] size,
                            input logic [7:0] burst);
    toRam = dir;
    busStartAddr = bStart;
    ramStartAddr = rStart;
    blockSize = size;
    burstSize = burst;
    start = 1;
    stepCycle();
    start = 0;
  endtask

  task automatic checkMem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (ram[i] !== expMem[i]) bad++;
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("FAIL %s mem: %0d words differ, required 0", name, bad);
    end
  endtask

  task automatic preloadWord(input int addr, input logic [31:0] d);
    tbWe = 1;
    tbAddr = 9'(addr);
    tbData = d;
    expMem[addr] = d;
    stepCycle();
    tbWe = 0;
  endtask

  task automatic doTransfer(input string name, input logic dir,
                            input logic [31:0] bStart, input logic [8:0] rStart,
                            input int size, input int burst, input int stallBeat,
                            input int extraBeat, input logic [31:0] dataBase,
                            input bit spamStart);
    int bursts[$];
    int nBursts, rem, b, phase, given, toGive, curBeats, beatIdx;
    int validCyc, stallsLeft, stallsInBurst, globalBeat, ramPtr;
    int endSeen, lastEndCyc, cyc;
    logic [31:0] busPtr, d;
    bit done;
    rem = size;
    while (rem > 0) begin
      b = (rem > burst + 1) ? burst + 1 : rem;
      bursts.push_back(b);
      rem -= b;
    end
    nBursts = bursts.size();
    ramPtr = int'(rStart);
    busPtr = {bStart[31:2], 2'b00};
    globalBeat = 0; phase = 0; done = 0; lastEndCyc = -10; endSeen = 0;
    given = 0; toGive = 0; curBeats = 0; beatIdx = 0; validCyc = 0;
    stallsLeft = 2; stallsInBurst = 0;
    pulseStart(dir, bStart, rStart, 10'(size), 8'(burst));
`ifdef RAM_DMA_DONE_IRQ_EN
    testsRun++;
    if (doneIrq !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s irqClear: doneIrq=%b required 0", name, doneIrq);
    end
`endif
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      busGrant = requestBus;
      dataValidIn = 0; dataIn = 0; endTransactionIn = 0; busBusy = 0;
      start = 0;
      if (!busy) begin
        done = 1;
        testsRun++;
        if (cyc - lastEndCyc != 2) begin
          testsFailed++;
          $display("FAIL %s busyFall: %0d cycles after end, required 2",
                   name, cyc - lastEndCyc);
        end
`ifdef RAM_DMA_DONE_IRQ_EN
        testsRun++;
        if (doneIrq !== 1'b1) begin
          testsFailed++;
          $display("FAIL %s irqSet: doneIrq=%b required 1", name, doneIrq);
        end
`endif
      end else begin
        if (spamStart && (cyc == 1 || cyc == 4)) begin
          start = 1; toRam = ~dir; blockSize = 10'd7;
          ramStartAddr = rStart + 9'd3; burstSize = 8'd1;
        end
        if (phase == 1) begin
          if (given < toGive) begin
            if ($urandom_range(0, 2) != 0) begin
              d = (dataBase != 0) ? dataBase + 32'(globalBeat) : $urandom;
              dataValidIn = 1;
              dataIn = d;
              if (given < curBeats) begin
                expMem[ramPtr] = d;
                ramPtr = (ramPtr + 1) % 512;
                globalBeat++;
              end
              given++;
            end
          end else begin
            endTransactionIn = 1;
            phase = 0;
            lastEndCyc = cyc;
            endSeen++;
          end
        end
        if (phase == 2 && dataValidOut) begin
          validCyc++;
          testsRun++;
          if (addressData !== expMem[ramPtr]) begin
            testsFailed++;
            $display("FAIL %s beat%0d: data %h required %h", name,
                     globalBeat, addressData, expMem[ramPtr]);
          end
          if (globalBeat == stallBeat && stallsLeft > 0) begin
            busBusy = 1;
            stallsLeft--;
            stallsInBurst++;
          end else begin
            ramPtr = (ramPtr + 1) % 512;
            globalBeat++;
            beatIdx++;
          end
        end
        if (endTransactionOut) begin
          testsRun++;
          if (phase != 2 || beatIdx != curBeats
              || validCyc != curBeats + stallsInBurst) begin
            testsFailed++;
            $display("FAIL %s endWrite: beats %0d valid cycles %0d, required %0d and %0d",
                     name, beatIdx, validCyc, curBeats, curBeats + stallsInBurst);
          end
          phase = 0;
          lastEndCyc = cyc;
          endSeen++;
        end
        if (beginTransaction) begin
          curBeats = (bursts.size() > 0) ? bursts.pop_front() : 1;
          testsRun++;
          if (addressData !== busPtr || readNotWrite !== dir
              || burstLength !== 8'(curBeats - 1)) begin
            testsFailed++;
            $display("FAIL %s begin: addr %h rnw %b len %0d, required %h %b %0d",
                     name, addressData, readNotWrite, burstLength,
                     busPtr, dir, curBeats - 1);
          end
          busPtr = busPtr + 32'(4 * curBeats);
          phase = dir ? 1 : 2;
          given = 0; toGive = curBeats + extraBeat;
          beatIdx = 0; validCyc = 0; stallsInBurst = 0;
        end
      end
      stepCycle();
    end
    busGrant = 0; dataValidIn = 0; endTransactionIn = 0; busBusy = 0;
    testsRun++;
    if (!done || endSeen != nBursts || errorFlag !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s complete: done %b bursts %0d err %b, required 1 %0d 0",
               name, done, endSeen, errorFlag, nBursts);
    end
    checkMem(name);
  endtask

  task automatic test_reset();
    stepCycle();
    testsRun++;
    if ({busy, errorFlag, requestBus, beginTransaction, dataValidOut,
         endTransactionOut, ramWriteEnableB, readNotWrite} !== 8'h00
        || addressData !== 0 || ramAddressB !== 0 || burstLength !== 0
        || ramDataInB !== 0) begin
      testsFailed++;
      $display("FAIL reset: busy %b req %b addr %h, required all 0",
               busy, requestBus, addressData);
    end
    for (int i = 0; i < 512; i++) preloadWord(i, $urandom);
    #2 reset = 1;
    stepCycle();
    testsRun++;
    if (busy !== 0 || requestBus !== 0 || errorFlag !== 0) begin
      testsFailed++;
      $display("FAIL resetRelease: busy %b req %b err %b, required 0 0 0",
               busy, requestBus, errorFlag);
    end
  endtask

  task automatic test_bus_to_ram();
    doTransfer("busToRam", 1, 32'h1000, 9'd0, 8, 3, -1, 0, 32'hA0, 0);
  endtask

  task automatic test_ram_to_bus();
    for (int i = 0; i < 5; i++) preloadWord(10 + i, 32'h11 + 32'(i));
    doTransfer("ramToBus", 0, 32'h4000, 9'd10, 5, 7, 2, 0, 0, 0);
  endtask

  task automatic test_wrap();
    doTransfer("wrapRam", 1, 32'h5000, 9'd510, 4, 3, -1, 1, 0, 0);
    doTransfer("wrapBus", 0, 32'hFFFF_FFF6, 9'd508, 6, 1, -1, 0, 0, 0);
  endtask

  task automatic test_max_block();
    doTransfer("maxBlock", 1, 32'h8000, 9'd0, 512, 255, -1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic dir;
    int size;
    for (int i = 0; i < 6; i++) begin
      dir = 1'($urandom_range(0, 1));
      size = $urandom_range(1, 40);
      doTransfer("random", dir, $urandom, 9'($urandom), size,
                 $urandom_range(0, 15),
                 dir ? -1 : $urandom_range(0, size - 1),
                 dir ? $urandom_range(0, 1) : 0, 0, 0);
    end
  endtask

  task automatic test_ignore_start();
    doTransfer("ignoreStart", 1, 32'h6000, 9'd200, 4, 3, -1, 0, 0, 1);
  endtask

  task automatic test_error();
    logic [31:0] d;
    pulseStart(1, 32'h3000, 9'd100, 10'd4, 8'd3);
    busGrant = 1;
    stepCycle();
    testsRun++;
    if (beginTransaction !== 1'b1) begin
      testsFailed++;
      $display("FAIL errBegin: begin %b required 1", beginTransaction);
    end
    busGrant = 0;
    stepCycle();
    d = $urandom;
    dataValidIn = 1; dataIn = d; expMem[100] = d;
    stepCycle();
    dataIn = $urandom; busErrorIn = 1;
    #1;
    testsRun++;
    if (ramWriteEnableB !== 1'b0) begin
      testsFailed++;
      $display("FAIL errBeat: write enable %b required 0", ramWriteEnableB);
    end
    stepCycle();
    busErrorIn = 0; dataIn = $urandom;
    #1;
    testsRun++;
    if (busy !== 1 || requestBus !== 0 || ramWriteEnableB !== 0
        || errorFlag !== 1) begin
      testsFailed++;
      $display("FAIL errFlush: busy %b req %b we %b err %b, required 1 0 0 1",
               busy, requestBus, ramWriteEnableB, errorFlag);
    end
    stepCycle();
    dataValidIn = 0;
    testsRun++;
    if (busy !== 0 || errorFlag !== 1) begin
      testsFailed++;
      $display("FAIL errDone: busy %b err %b, required 0 1", busy, errorFlag);
    end
`ifdef RAM_DMA_DONE_IRQ_EN
    testsRun++;
    if (doneIrq !== 1'b1) begin
      testsFailed++;
      $display("FAIL errIrq: doneIrq %b required 1", doneIrq);
    end
`endif
    checkMem("error");
  endtask

  task automatic test_zero_length();
    pulseStart(1, 32'h0, 9'd0, 10'd0, 8'd0);
    testsRun++;
    if (busy !== 1 || requestBus !== 0 || errorFlag !== 0) begin
      testsFailed++;
      $display("FAIL zeroStart: busy %b req %b err %b, required 1 0 0",
               busy, requestBus, errorFlag);
    end
    stepCycle();
    testsRun++;
    if (busy !== 0 || requestBus !== 0) begin
      testsFailed++;
      $display("FAIL zeroEnd: busy %b req %b, required 0 0", busy, requestBus);
    end
`ifdef RAM_DMA_DONE_IRQ_EN
    testsRun++;
    if (doneIrq !== 1'b1) begin
      testsFailed++;
      $display("FAIL zeroIrq: doneIrq %b required 1", doneIrq);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    bit found;
    found = 0;
    pulseStart(0, 32'h2000, 9'd40, 10'd8, 8'd7);
    for (int c = 0; c < 50 && !found; c++) begin
      busGrant = requestBus;
      if (dataValidOut) found = 1;
      else stepCycle();
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("FAIL reachWrite: dataValidOut never 1, required 1");
    end
    #2 reset = 0;
    #1;
    testsRun++;
    if ({busy, errorFlag, requestBus, beginTransaction, dataValidOut,
         endTransactionOut, ramWriteEnableB, readNotWrite} !== 8'h00
        || addressData !== 0 || ramAddressB !== 0 || burstLength !== 0) begin
      testsFailed++;
      $display("FAIL asyncReset: busy %b req %b valid %b addr %h, required all 0",
               busy, requestBus, dataValidOut, addressData);
    end
`ifdef RAM_DMA_DONE_IRQ_EN
    testsRun++;
    if (doneIrq !== 1'b0) begin
      testsFailed++;
      $display("FAIL resetIrq: doneIrq %b required 0", doneIrq);
    end
`endif
    busGrant = 0;
    stepCycle();
    #2 reset = 1;
    stepCycle();
    doTransfer("afterReset", 0, 32'h2000, 9'd40, 8, 7, 4, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_bus_to_ram();
    test_ram_to_bus();
    test_wrap();
    test_max_block();
    test_random();
    test_ignore_start();
    test_error();
    test_zero_length();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ram_dma_port_b_engine.md
Name: ram_dma_port_b_engine

Overview:
- DMA master on port B of the 512x32 dual-port scratch SSRAM behind the custom-instruction (CI) RAM block.
- Moves blocks between system bus memory and the SSRAM in bursts, independently of the CPU.
- Port A stays with the CPU CI path.
- The CI decoder drives the configuration inputs and one-cycle start pulse; this block drives the SSRAM port B and the bus-master handshake.

Parameters:
- ramAddrWidth, 9, SSRAM word-address width (512 entries)
- blockSizeWidth, 10, width of block length in words (max 512)
- burstSizeWidth, 8, width of burst length field (burst = value+1 words, max 256)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from CI decoder; accepted only when busy=0
- toRam  in  1  1: bus->SSRAM; 0: SSRAM->bus
- busStartAddr  in  32  word-aligned bus byte address; bits[1:0] ignored
- ramStartAddr  in  ramAddrWidth  first SSRAM word
- blockSize  in  blockSizeWidth  words to move; 0 means no transfer
- burstSize  in  burstSizeWidth  burst length minus 1
- busy  out  1  high from accepted start until completion
- errorFlag  out  1  sticky bus error of last transfer; cleared by next accepted start
- ramAddressB  out  ramAddrWidth  SSRAM port B address
- ramWriteEnableB  out  1  SSRAM port B write strobe
- ramDataInB  out  32  write data to SSRAM
- ramDataOutB  in  32  SSRAM read data, registered, 1-cycle latency
- requestBus  out  1  bus request
- busGrant  in  1  bus grant
- beginTransaction  out  1  one-cycle transaction start
- addressData  out  32  address during beginTransaction, data during write beats, else 0
- readNotWrite  out  1  transaction direction, valid with beginTransaction
- burstLength  out  burstSizeWidth  beats minus 1, valid with beginTransaction
- dataValidOut  out  1  write beat valid
- busBusy  in  1  slave stall; holds the current write beat
- dataValidIn  in  1  read beat valid
- dataIn  in  32  read beat data
- endTransactionIn  in  1  slave ends read transaction
- endTransactionOut  out  1  one-cycle end after last write beat
- busErrorIn  in  1  bus error

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters 0.
- Start handling:
  - start while busy=1 is ignored.
  - Accepted start latches all config inputs and clears errorFlag.
  - With blockSize=0, busy pulses high for exactly one cycle.
- FSM states: IDLE, REQUEST, BEGIN, READ_BEATS, PREFETCH, WRITE_BEATS, END_WRITE, NEXT, ERROR_FLUSH.
- IDLE -> REQUEST on accepted nonzero start.
- REQUEST:
  - requestBus=1 until busGrant, then BEGIN.
  - requestBus stays 1 through the burst and drops in NEXT.
- BEGIN (one cycle):
  - beginTransaction=1.
  - burstLength = min(burstSize, remaining-1).
  - readNotWrite = toRam.
- Bus->SSRAM path (READ_BEATS):
  - Each dataValidIn cycle: ramWriteEnableB=1, ramDataInB=dataIn, ramAddressB=current; then ramAddress+1, busAddress+4, remaining-1.
  - Beats beyond the programmed burst are dropped.
  - endTransactionIn -> NEXT.
- SSRAM->bus path (PREFETCH):
  - One cycle presenting ramAddressB, since port B read latency is 1.
- WRITE_BEATS:
  - dataValidOut=1 and addressData=ramDataOutB.
  - busBusy=1 holds the beat and the address unchanged.
  - Otherwise advance, and ramAddressB pre-advances so the next beat is back-to-back.
  - After the last beat -> END_WRITE: endTransactionOut=1 for one cycle -> NEXT.
- NEXT:
  - remaining=0 -> IDLE and busy=0.
  - Otherwise -> REQUEST.
- Address wrap-around: SSRAM address wraps modulo 2^ramAddrWidth; bus address wraps modulo 2^32.
- Bus error:
  - busErrorIn in any non-IDLE state sets errorFlag and goes to ERROR_FLUSH.
  - ERROR_FLUSH: requestBus=0, no further SSRAM writes, then IDLE next cycle.
- busErrorIn and dataValidIn in the same cycle: the error wins and the beat is not written.
- Reset mid-operation aborts immediately; outputs return to reset values asynchronously.
- Port A contention: the CPU may access the same word concurrently. That ordering is software's responsibility; this block does not arbitrate.

Optional Feature:
- RAM_DMA_DONE_IRQ_EN
- Defined: adds output doneIrq, 1 bit.
  - Set on the cycle busy falls, including error and zero-length cases.
  - Held until the next accepted start or reset.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package ram_dma_pkg:
  - FSM state enum.
  - Default widths (9/10/8).
  - Byte increment constant 4.
- One natural sub-module, ram_dma_burst_counter: loads the min(burst, remaining) beat count and asserts last-beat; it is used by both directions.

Test Plan:
- Bus->SSRAM, toRam=1, busStartAddr=0x1000, ramStartAddr=0, blockSize=8, burstSize=3, slave returns 0xA0+i -> two bursts each with burstLength=3; SSRAM[0..7]=0xA0..0xA7; busy falls after the second endTransactionIn.
- SSRAM->bus, SSRAM[10..14]=0x11..0x15, blockSize=5, burstSize=7 -> one burst with burstLength=4; write beats 0x11..0x15 back-to-back; busBusy asserted for 2 cycles on beat 3 holds 0x13; endTransactionOut pulses once.
- Wrap-around, ramStartAddr=510, blockSize=4, toRam=1 -> words written to 510, 511, 0, 1.
- Error, busErrorIn on the 2nd read beat of a 4-beat burst -> only beat 1 is written; errorFlag=1; busy=0 two cycles later; next start clears errorFlag.
- start with blockSize=0 -> busy high for 1 cycle; no requestBus. A start pulsed while busy=1 is ignored, with no change to transfer count.
- Reset low mid-WRITE_BEATS -> all outputs 0 asynchronously; after release a new start completes normally. With RAM_DMA_DONE_IRQ_EN defined, doneIrq sets at completion and clears on start.
